// File: rtl/seg_bcd_ctrl_if.sv
// Request handshake and display-peripheral bus bundled for seg_bcd_ctrl.
// The controller connects through the slave modport; the requester/peripheral side uses master.
interface seg_bcd_ctrl_if;
  logic        req_valid;
  logic [31:0] req_data;
  logic        req_ready;
  logic        busy;
  logic        ovf;
  logic        err;
  logic        seg_cs_n;
  logic        seg_rw;
  logic [31:0] seg_mosi;
  logic [31:0] seg_miso;

  modport slave (
    input  req_valid, req_data, seg_miso,
    output req_ready, busy, ovf, err, seg_cs_n, seg_rw, seg_mosi
  );

  modport master (
    output req_valid, req_data, seg_miso,
    input  req_ready, busy, ovf, err, seg_cs_n, seg_rw, seg_mosi
  );
endinterface

// File: rtl/seg_bcd_ctrl.sv
// seg_bcd_ctrl: binary-to-BCD display controller.
// Accepts a 32-bit binary value, converts it with a serial double-dabble (one bit per cycle),
// then writes the packed 8-digit BCD result to the display peripheral in a one-cycle WRITE.
// Values above MAX_BIN are not converted; SAT_BCD is written instead and ovf is raised.
// Optional macro SEG_READBACK_EN adds a READ cycle and a CHECK cycle that compares seg_miso
// against the written result and sets the sticky err flag on mismatch.
module seg_bcd_ctrl #(
  parameter int unsigned MAX_BIN = 99_999_999,
  parameter logic [31:0] SAT_BCD = 32'h9999_9999
) (
  input logic          sck,
  input logic          rst,
  seg_bcd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StConv  = 3'd1,
    StWrite = 3'd2,
    StRead  = 3'd3,
    StCheck = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] bin_q;     // remaining binary bits, consumed MSB first
  logic [31:0] bcd_q;     // double-dabble working register
  logic [31:0] result_q;  // last completed result, drives seg_mosi
  logic [4:0]  cnt_q;     // CONV bit counter
  logic        ovf_q;
  logic        err_q;
  logic        accept;
  logic        over_max;
  logic [31:0] bcd_adj;
  logic [31:0] bcd_shift;

  assign accept   = (state_q == StIdle) && bus.req_valid;
  assign over_max = (bus.req_data > MAX_BIN);

  // Add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 8; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    bcd_shift = {bcd_adj[30:0], bin_q[31]};
  end

  // State register.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = over_max ? StWrite : StConv;
        end
      end
      StConv: begin
        if (cnt_q == 5'd31) begin
          state_d = StWrite;
        end
      end
`ifdef SEG_READBACK_EN
      StWrite: state_d = StRead;
      StRead:  state_d = StCheck;
      StCheck: state_d = StIdle;
`else
      StWrite: state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Request latch, serial conversion and result capture.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        if (over_max) begin
          ovf_q    <= 1'b1;
          result_q <= SAT_BCD;
        end else begin
          ovf_q <= 1'b0;
          bin_q <= bus.req_data;
          bcd_q <= '0;
          cnt_q <= '0;
        end
      end else if (state_q == StConv) begin
        bcd_q <= bcd_shift;
        bin_q <= {bin_q[30:0], 1'b0};
        cnt_q <= cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_q <= bcd_shift;
        end
      end
    end
  end

`ifdef SEG_READBACK_EN
  // Sticky readback mismatch flag, cleared only by reset.
  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StCheck) && (bus.seg_miso != result_q)) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = ^bus.seg_miso;
  assign err_q       = 1'b0;
`endif

  // Bus outputs decode directly from state so reset takes effect without a clock.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign bus.seg_cs_n  = !((state_q == StWrite) || (state_q == StRead));
  assign bus.seg_rw    = (state_q == StWrite);
  assign bus.seg_mosi  = result_q;

endmodule

// File: tb/tb_seg_bcd_ctrl.sv
// Self-checking bench for seg_bcd_ctrl: directed and random requests checked against a
// decimal-digit reference model (repeated divide by ten), including latency, overflow,
// held req_valid, reset abort and, with SEG_READBACK_EN, the readback error flag.
module tb_seg_bcd_ctrl;

  localparam int unsigned MAX_BIN = 99_999_999;
  localparam logic [31:0] SAT_BCD = 32'h9999_9999;

  logic sck;
  logic rst;
  seg_bcd_ctrl_if bus ();

  seg_bcd_ctrl #(
    .MAX_BIN(MAX_BIN),
    .SAT_BCD(SAT_BCD)
  ) dut (
    .sck(sck),
    .rst(rst),
    .bus(bus)
  );

  initial sck = 1'b0;
  always #5 sck = ~sck;

  int          vectors = 0;
  int          fails   = 0;
  logic [31:0] last_w  = 32'h0;
  logic        err_model = 1'b0;

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = 32'h0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_ready"}, bus.req_ready, 1'b1);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_ovf"}, bus.ovf, 1'b0);
    chk1({tag, "_err"}, bus.err, 1'b0);
    chk1({tag, "_cs_n"}, bus.seg_cs_n, 1'b1);
    chk1({tag, "_rw"}, bus.seg_rw, 1'b0);
    chk({tag, "_mosi"}, bus.seg_mosi, 32'h0);
  endtask

  // One request from IDLE through WRITE (and readback) back to IDLE.
  task automatic do_req(input logic [31:0] v, input bit hold_valid, input bit bad_miso);
    logic [31:0] exp_w;
    logic        exp_ovf;
    int          exp_lat;
    int          lat;
    exp_ovf = (v > MAX_BIN);
    exp_w   = exp_ovf ? SAT_BCD : to_bcd(v);
    exp_lat = exp_ovf ? 1 : 33;
    bus.seg_miso = bad_miso ? 32'h0 : exp_w;
    chk1("ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_data  = v;
    tick();
    if (!hold_valid) bus.req_valid = 1'b0;
    bus.req_data = $urandom;
    lat = 1;
    while (bus.seg_cs_n !== 1'b0 && lat < 40) begin
      chk1("conv_busy", bus.busy, 1'b1);
      chk("conv_mosi_hold", bus.seg_mosi, last_w);
      if (lat == 1) chk1("conv_ovf", bus.ovf, exp_ovf);
      tick();
      bus.req_data = $urandom;
      lat++;
    end
    chk("write_latency", 32'(lat), 32'(exp_lat));
    chk1("write_rw", bus.seg_rw, 1'b1);
    chk("write_mosi", bus.seg_mosi, exp_w);
    chk1("write_ovf", bus.ovf, exp_ovf);
    chk1("write_busy", bus.busy, 1'b1);
    last_w = exp_w;
    tick();
`ifdef SEG_READBACK_EN
    chk1("read_cs_n", bus.seg_cs_n, 1'b0);
    chk1("read_rw", bus.seg_rw, 1'b0);
    tick();
    chk1("check_cs_n", bus.seg_cs_n, 1'b1);
    chk1("check_busy", bus.busy, 1'b1);
    tick();
    if (bad_miso && exp_w != 32'h0) err_model = 1'b1;
`endif
    chk1("idle_cs_n", bus.seg_cs_n, 1'b1);
    chk1("idle_rw", bus.seg_rw, 1'b0);
    chk1("idle_ready", bus.req_ready, 1'b1);
    chk1("idle_ovf", bus.ovf, exp_ovf);
    chk1("idle_err", bus.err, err_model);
    chk("idle_mosi", bus.seg_mosi, exp_w);
  endtask

  initial begin
    int pulses;
    logic [31:0] rv;
    bus.req_valid = 1'b0;
    bus.req_data  = 32'h0;
    bus.seg_miso  = 32'h0;
    rst = 1'b1;
    #3;
    chk_reset_values("por");
    tick();
    tick();
    #2 rst = 1'b0;

    // Directed values: first accept right after reset release.
    do_req(32'd12345678, 1'b0, 1'b0);
    do_req(32'd0, 1'b0, 1'b0);
    do_req(32'd99_999_999, 1'b0, 1'b0);
    do_req(32'd100_000_000, 1'b0, 1'b0);
    do_req(32'hFFFF_FFFF, 1'b0, 1'b0);
    do_req(32'd7, 1'b0, 1'b0);

    // Random in-range and out-of-range values.
    for (int i = 0; i < 10; i++) begin
      if (($urandom % 4) == 0) rv = $urandom;
      else rv = $urandom_range(MAX_BIN, 0);
      do_req(rv, 1'b0, 1'b0);
    end

    // req_valid held high across several transactions with changing data.
    for (int i = 0; i < 4; i++) begin
      rv = $urandom_range(MAX_BIN, 0);
      do_req(rv, 1'b1, 1'b0);
    end
    bus.req_valid = 1'b0;

    // Reset 10 cycles into CONV aborts with no write.
    bus.req_valid = 1'b1;
    bus.req_data  = 32'd4242;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    chk1("preabort_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("abort");
    last_w    = 32'h0;
    err_model = 1'b0;
    tick();
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.seg_cs_n === 1'b0) pulses++;
    end
    chk("abort_no_pulse", 32'(pulses), 32'h0);
    chk1("abort_idle", bus.req_ready, 1'b1);
    do_req(32'd5, 1'b0, 1'b0);

`ifdef SEG_READBACK_EN
    // Mismatching readback sets err; it stays set through later good transactions.
    do_req(32'd5, 1'b0, 1'b1);
    do_req(32'd31415, 1'b0, 1'b0);
    do_req(32'd100_000_001, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_reset_values("rb_reset");
    last_w    = 32'h0;
    err_model = 1'b0;
    #2 rst = 1'b0;
    do_req(32'd5, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/seg_bcd_ctrl.md
SEG_BCD_CTRL -- requirements
Module: seg_bcd_ctrl

Interface
REQ-001 SHALL have parameter MAX_BIN, default 99_999_999: largest binary value converted exactly.
REQ-002 SHALL have parameter SAT_BCD, default 32'h9999_9999: BCD pattern written when the input exceeds MAX_BIN.
REQ-003 SHALL have port sck, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: a binary display request is present.
REQ-006 SHALL have port req_data, input, 32: unsigned binary value to display.
REQ-007 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-008 SHALL have port busy, output, 1: a conversion or bus transaction is in progress.
REQ-009 SHALL have port ovf, output, 1: last accepted request exceeded MAX_BIN.
REQ-010 SHALL have port err, output, 1: readback mismatch (sticky).
REQ-011 SHALL have port seg_cs_n, output, 1: display peripheral chip select, active-low.
REQ-012 SHALL have port seg_rw, output, 1: display peripheral direction; 1 = write, 0 = read.
REQ-013 SHALL have port seg_mosi, output, 32: packed BCD write data, digit 0 in bits [3:0].
REQ-014 SHALL have port seg_miso, input, 32: display peripheral readback register.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, WRITE, READ, CHECK.
REQ-016 SHALL assert req_ready only in IDLE; busy SHALL equal the inverse of req_ready.
REQ-017 Acceptance SHALL occur on an edge with req_valid=1 and req_ready=1; req_data is latched on that edge only.
REQ-018 Accept with req_data <= MAX_BIN: SHALL clear ovf and enter CONV.
REQ-019 Accept with req_data > MAX_BIN: SHALL set ovf, load SAT_BCD as the result, and go directly to WRITE.
REQ-020 CONV SHALL run the shift-add-3 (double-dabble) algorithm at one bit per cycle, MSB first, for exactly 32 cycles, then go to WRITE.
REQ-021 The adjust-by-3 SHALL be applied to each 4-bit BCD digit that is >= 5 before each shift; the result register SHALL be 32 bits (8 digits).
REQ-022 WRITE SHALL last exactly one cycle with seg_cs_n=0, seg_rw=1, seg_mosi=result.
REQ-023 Latency SHALL be: WRITE is the 33rd cycle after the accept edge for in-range values, and the 1st cycle after it for overflow values.
REQ-024 Outside WRITE and READ, seg_cs_n SHALL be 1, seg_rw SHALL be 0, and seg_mosi SHALL hold the last result.
REQ-025 req_valid seen while busy SHALL be ignored, with no queuing and no effect on outputs.
REQ-026 Value 0 SHALL convert to 32'h0000_0000; there SHALL be no leading-zero blanking.
REQ-027 Without SEG_READBACK_EN, WRITE SHALL return to IDLE; READ and CHECK are then unused.

Reset
REQ-028 rst=1 SHALL force the following immediately, independent of sck: state=IDLE, req_ready=1, busy=0, ovf=0, err=0, seg_cs_n=1, seg_rw=0, seg_mosi=0, result=0.
REQ-029 rst asserted mid-CONV or mid-WRITE SHALL abort the operation with no further seg_cs_n pulse.
REQ-030 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro SEG_READBACK_EN defined: WRITE SHALL go to READ, which holds seg_cs_n=0 and seg_rw=0 for one cycle; CHECK SHALL then compare seg_miso with result, set err on mismatch, and return to IDLE.
REQ-032 Macro SEG_READBACK_EN defined: the round trip SHALL take 2 extra cycles, and err SHALL clear only on rst.
REQ-033 Macro SEG_READBACK_EN undefined: err SHALL be constant 0 and seg_miso SHALL be unused.

Verification
REQ-034 Stimulus: req_data=12345678 accepted. Required: seg_mosi=32'h1234_5678 with seg_cs_n=0 and seg_rw=1 for exactly one cycle, 33 cycles after accept; ovf=0.
REQ-035 Stimulus: req_data=0, then req_data=99_999_999. Required: writes of 32'h0000_0000 and then 32'h9999_9999; ovf=0 for both.
REQ-036 Stimulus: req_data=100_000_000. Required: write of 32'h9999_9999 one cycle after accept; ovf=1 until the next accept.
REQ-037 Stimulus: req_valid held high continuously with changing req_data. Required: exactly one accept per IDLE visit; intermediate data is never written.
REQ-038 Stimulus: rst pulsed 10 cycles into CONV. Required: outputs at reset values immediately; no seg_cs_n=0 pulse until a new accept.
REQ-039 Stimulus (SEG_READBACK_EN): seg_miso forced to 32'h0 during READ/CHECK for req_data=5. Required: err=1 and it stays 1 until rst; with a matching seg_miso, err=0.
